// File: rtl/ysyx_23060191_muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide sequencer.
// Contents:
//   XLEN / OP_W / CNT_W  - datapath, op-code and loop-counter widths
//   op_e                 - RV32M funct3 operation codes
//   state_e              - controller state encoding
//   step_mode_e          - selects multiply or divide iteration in the step unit
//   op_info_t            - decoded operation attributes
//   decode_op()          - funct3 -> op_info_t
//   cond_neg()           - conditional two's-complement negate
package ysyx_23060191_muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int OP_W  = 3;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [OP_W-1:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  // Result constants for the divide special cases.
  localparam logic [XLEN-1:0] QUOT_ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN       = {1'b1, {(XLEN-1){1'b0}}};

  typedef struct packed {
    logic is_div;    // divide group (DIV/DIVU/REM/REMU)
    logic is_rem;    // remainder result wanted
    logic mul_high;  // multiply returns the upper half of the product
    logic signed1;   // rs1 treated as signed
    logic signed2;   // rs2 treated as signed
  } op_info_t;

  // funct3 layout: bit2 selects divide; in the divide group bit1 selects
  // remainder and bit0 selects unsigned. In the multiply group only MULHU
  // treats rs1 as unsigned, and only MUL/MULH treat rs2 as signed.
  function automatic op_info_t decode_op(input logic [OP_W-1:0] op);
    op_info_t info;
    info.is_div   = op[2];
    info.is_rem   = op[2] & op[1];
    info.mul_high = ~op[2] & (op[1:0] != 2'b00);
    info.signed1  = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    info.signed2  = op[2] ? ~op[0] : ~op[1];
    return info;
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                               input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/ysyx_23060191_muldiv_step.sv
// Combinational single iteration of the multiply/divide loop.
// Ports:
//   mode     in   STEP_MUL: shift-add multiply, STEP_DIV: restoring divide
//   hi_in    in   XLEN+1  mul: upper accumulator half; div: partial remainder
//   lo_in    in   XLEN    mul: lower half / remaining multiplier bits;
//                         div: remaining dividend bits / quotient bits so far
//   operand  in   XLEN    mul: multiplicand magnitude; div: divisor magnitude
//   hi_out   out  XLEN+1  next hi
//   lo_out   out  XLEN    next lo
module ysyx_23060191_muldiv_step
  import ysyx_23060191_muldiv_pkg::*;
(
  input  step_mode_e      mode,
  input  logic [XLEN:0]   hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN:0]   hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path can leave it unassigned and infer a latch.
    hi_out  = hi_in;
    lo_out  = lo_in;

    // Multiply: add the multiplicand when the current multiplier bit (lo[0])
    // is set, then shift the {carry, hi, lo} accumulator right by one.
    addend  = lo_in[0] ? operand : '0;
    sum     = {1'b0, hi_in[XLEN-1:0]} + {1'b0, addend};

    // Divide: bring the next dividend bit into the partial remainder and try
    // subtracting the divisor; a borrow (diff MSB) means restore.
    shifted = {hi_in[XLEN-1:0], lo_in[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, operand};

    if (mode == STEP_MUL) begin
      hi_out = {1'b0, sum[XLEN:1]};
      lo_out = {sum[0], lo_in[XLEN-1:1]};
    end else if (diff[XLEN+1]) begin
      hi_out = shifted;
      lo_out = {lo_in[XLEN-2:0], 1'b0};
    end else begin
      hi_out = diff[XLEN:0];
      lo_out = {lo_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/ysyx_23060191_muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer. Accepts one operation over a
// valid/ready handshake, runs XLEN shift-add or restoring-divide iterations
// and holds the registered result until the consumer takes it.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   in_valid     request valid           in_ready    request can be accepted
//   in_op        RV32M funct3 op code    in_src1/2   rs1 / rs2 operands
//   flush        abandon any in-flight operation (synchronous)
//   out_valid    result valid            out_ready   consumer takes result
//   out_result   registered result       busy        controller not idle
module ysyx_23060191_muldiv_ctrl
  import ysyx_23060191_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [XLEN:0]    hi_q;
  logic [XLEN-1:0]  lo_q;
  logic [XLEN-1:0]  opnd_q;
  op_info_t         info_q;
  logic             neg_q;
  logic [XLEN-1:0]  result_q;

  logic             accept;
  logic             last_step;

  // ---------------------------------------------------------------------------
  // Request decode (operands as presented this cycle)
  // ---------------------------------------------------------------------------
  op_info_t        info_in;
  logic            s1, s2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_result;

  always_comb begin
    info_in  = decode_op(in_op);
    s1       = info_in.signed1 & in_src1[XLEN-1];
    s2       = info_in.signed2 & in_src2[XLEN-1];
    mag1     = cond_neg(in_src1, s1);
    mag2     = cond_neg(in_src2, s2);
    div_zero = info_in.is_div & (in_src2 == '0);
    div_ovf  = info_in.is_div & info_in.signed1 &
               (in_src1 == INT_MIN) & (in_src2 == QUOT_ALL_ONES);
    special  = div_zero | div_ovf;
    if (div_zero) special_result = info_in.is_rem ? in_src1 : QUOT_ALL_ONES;
    else          special_result = info_in.is_rem ? '0 : INT_MIN;
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   hi_step;
  logic [XLEN-1:0] lo_step;
  step_mode_e      step_mode;

  assign step_mode = info_q.is_div ? STEP_DIV : STEP_MUL;

  ysyx_23060191_muldiv_step u_step (
    .mode    (step_mode),
    .hi_in   (hi_q),
    .lo_in   (lo_q),
    .operand (opnd_q),
    .hi_out  (hi_step),
    .lo_out  (lo_step)
  );

  // Result assembled from the final iteration's outputs, with sign fix-up,
  // so it can be registered on the same edge that enters DONE.
  logic [2*XLEN-1:0] product, product_fix;
  logic [XLEN-1:0]   final_result;

  always_comb begin
    product     = {hi_step[XLEN-1:0], lo_step};
    product_fix = neg_q ? (~product + 1'b1) : product;
    if (info_q.is_div)
      final_result = info_q.is_rem ? cond_neg(hi_step[XLEN-1:0], neg_q)
                                   : cond_neg(lo_step, neg_q);
    else
      final_result = info_q.mul_high ? product_fix[2*XLEN-1:XLEN]
                                     : product_fix[XLEN-1:0];
  end

  assign accept    = in_valid & in_ready;
  assign last_step = (cnt_q == CNT_W'(XLEN-1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (flush)          state_d = ST_IDLE;
        else if (last_step) state_d = ST_DONE;
      end
      ST_DONE: if (flush || out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // rst is folded in because the state register only reflects reset after
    // it has propagated; in_ready must read low for the whole reset window.
    in_ready   = (state_q == ST_IDLE) & ~flush & ~rst;
    out_valid  = (state_q == ST_DONE);
    busy       = (state_q != ST_IDLE);
    out_result = result_q;
  end

  // ---------------------------------------------------------------------------
  // Operand / accumulator / counter / result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      info_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= mag1;
      opnd_q <= mag2;
      info_q <= info_in;
      // Remainder takes the dividend's sign; product and quotient s1^s2.
      neg_q  <= info_in.is_rem ? s1 : (s1 ^ s2);
      if (special) result_q <= special_result;
    end else if (state_q == ST_CALC && !flush) begin
      hi_q  <= hi_step;
      lo_q  <= lo_step;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_step) result_q <= final_result;
    end
  end

endmodule

// File: tb/tb_ysyx_23060191_muldiv_ctrl.sv
// Directed bench for the RV32M multiply/divide sequencer: a table of
// operations with hand-computed results and latencies, followed by
// backpressure, flush and mid-operation reset sequences.
module tb_ysyx_23060191_muldiv_ctrl;
  import ysyx_23060191_muldiv_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_op;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            busy;

  ysyx_23060191_muldiv_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a request at the falling edge, let it be accepted on the next
  // rising edge, then scramble the inputs to prove they were latched.
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input string name);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = ~op;
    in_src1  = ~a;
    in_src2  = ~b;
  endtask

  // Cycles after the accept edge until out_valid is seen; capped at 100.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 100);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat, input string name);
    int cyc;
    out_ready = 1'b1;
    issue(op, a, b, name);
    wait_valid(cyc);
    check({name, " latency"}, 32'(cyc), 32'(lat));
    check({name, " result"}, out_result, exp);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  initial begin
    int cyc;
    logic seen;

    vecs[0]  = '{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{OP_MULH,   32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 33};
    vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{OP_MUL,    32'h80000000, 32'h00000002, 32'h00000000, 33};
    vecs[5]  = '{OP_MULH,   32'h80000000, 32'h00000002, 32'hFFFFFFFF, 33};
    vecs[6]  = '{OP_MULHU,  32'h80000000, 32'h00000002, 32'h00000001, 33};
    vecs[7]  = '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
    vecs[8]  = '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
    vecs[9]  = '{OP_DIVU,   32'hFFFFFFFF, 32'h00000002, 32'h7FFFFFFF, 33};
    vecs[10] = '{OP_REMU,   32'h0000000A, 32'h00000003, 32'h00000001, 33};
    vecs[11] = '{OP_DIV,    32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 33};
    vecs[12] = '{OP_REM,    32'h00000064, 32'hFFFFFFF9, 32'h00000002, 33};
    vecs[13] = '{OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[14] = '{OP_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
    vecs[15] = '{OP_DIV,    32'hFFFFFFF8, 32'hFFFFFFFF, 32'h00000008, 33};
    vecs[16] = '{OP_DIV,    32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1};
    vecs[17] = '{OP_REM,    32'h00000005, 32'h00000000, 32'h00000005, 1};
    vecs[18] = '{OP_REM,    32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 1};
    vecs[19] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[20] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_src1   = '0;
    in_src2   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst in_ready",   32'(in_ready),  32'd0);
    check("rst out_valid",  32'(out_valid), 32'd0);
    check("rst busy",       32'(busy),      32'd0);
    check("rst out_result", out_result,     32'd0);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", 32'(in_ready), 32'd1);

    // Table of operations
    for (int i = 0; i < NV; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
             $sformatf("vec%0d", i));

    // Extra divide-by-zero unsigned cases
    run_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu0");
    run_op(OP_REMU, 32'd5, 32'd0, 32'h00000005, 1, "remu0");

    // Backpressure: result held in DONE while out_ready is low
    out_ready = 1'b0;
    issue(OP_MUL, 32'h00000007, 32'hFFFFFFFD, "hold");
    wait_valid(cyc);
    check("hold latency", 32'(cyc), 32'd33);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d result", i),    out_result,     32'hFFFFFFEB);
      check($sformatf("hold%0d in_ready", i),  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("hold release out_valid", 32'(out_valid), 32'd0);
    check("hold release in_ready",  32'(in_ready),  32'd1);

    // Flush in CALC cycle 10: back to IDLE, no result produced
    issue(OP_DIVU, 32'd100, 32'd7, "flush");
    repeat (10) @(negedge clk);
    check("flush pre busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush busy",      32'(busy),      32'd0);
    check("flush out_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush no result", 32'(seen), 32'd0);
    run_op(OP_REMU, 32'd10, 32'd3, 32'd1, 33, "after flush");

    // Flush together with in_valid in IDLE: not accepted
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = OP_MUL;
    in_src1  = 32'd3;
    in_src2  = 32'd4;
    flush    = 1'b1;
    #1;
    check("flush idle in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush idle busy", 32'(busy), 32'd0);

    // Reset mid-CALC: outputs return to reset values immediately
    issue(OP_MUL, 32'd3, 32'd5, "rst mid");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst out_valid",  32'(out_valid), 32'd0);
    check("midrst busy",       32'(busy),      32'd0);
    check("midrst in_ready",   32'(in_ready),  32'd0);
    check("midrst out_result", out_result,     32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(OP_MULHU, 32'h80000000, 32'h00000002, 32'h00000001, 33,
           "after rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
